// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
//
// Deserializes the codec's I2S ADC stream on the codec bit clock. It presents
// one WORD_LENGTH-bit left sample and one right sample per frame, each with a
// one-cycle strobe. It also flags words cut short by an early word-select edge.
//
// Ports
//   clk          : codec bit clock (AUD_BCLK). Everything runs on its rising edge.
//   reset        : asynchronous, active-high reset.
//   AUD_ADCLRCK  : word select, 0 = left, 1 = right. Changes on the falling edge.
//   AUD_ADCDAT   : serial data, MSB first, one bit-clock after the LRCK edge.
//   Channel_L    : last complete left sample (two's complement).
//   Channel_R    : last complete right sample (two's complement).
//   shot_L       : one-cycle pulse when Channel_L is updated.
//   shot_R       : one-cycle pulse when Channel_R is updated.
//   frame_error  : one-cycle pulse when a word is truncated by an early LRCK edge.
module i2s_adc_receiver #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   AUD_ADCLRCK,
    input  logic                   AUD_ADCDAT,
    output logic [WORD_LENGTH-1:0] Channel_L,
    output logic [WORD_LENGTH-1:0] Channel_R,
    output logic                   shot_L,
    output logic                   shot_R,
    output logic                   frame_error
);

    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        ARM,      // one cycle after reset to load lrck_q; edges are not evaluated
        SYNC,     // discard data until the first observed LRCK edge
        CAPTURE,  // shifting in a word
        WAIT      // ignoring padding bits of a slot longer than WORD_LENGTH
    } state_t;

    state_t                 state;
    logic                   lrck_q;
    logic                   chan;
    logic [CW-1:0]          cnt;
    // The LSB is taken straight from the pin in the publish cycle, so only
    // WORD_LENGTH-1 bits ever need to be held.
    logic [WORD_LENGTH-2:0] shift;

    logic                   lrck_edge;
    logic [WORD_LENGTH-1:0] word_next;

    assign lrck_edge = (AUD_ADCLRCK != lrck_q);
    assign word_next = {shift, AUD_ADCDAT};

    // NOTE: all state uses non-blocking assignments, so every branch below sees
    // the values from before this edge. The publish and restart in the same
    // cycle depend on that.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register, including the sample outputs, is cleared by
        // reset. The outputs must read 0 immediately and never show a stale word.
        if (reset) begin
            state       <= ARM;
            lrck_q      <= 1'b0;
            chan        <= 1'b0;
            cnt         <= '0;
            shift       <= '0;
            Channel_L   <= '0;
            Channel_R   <= '0;
            shot_L      <= 1'b0;
            shot_R      <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            lrck_q      <= AUD_ADCLRCK;
            shot_L      <= 1'b0;
            shot_R      <= 1'b0;
            frame_error <= 1'b0;

            unique case (state)
                ARM: state <= SYNC;

                SYNC, WAIT: begin
                    // The bit sampled in the edge cycle belongs to the previous
                    // slot (I2S one-bit delay), so capture starts next cycle.
                    if (lrck_edge) begin
                        chan  <= AUD_ADCLRCK;
                        cnt   <= '0;
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    shift <= word_next[WORD_LENGTH-2:0];
                    if (cnt == LAST_BIT) begin
                        if (chan) begin
                            Channel_R <= word_next;
                            shot_R    <= 1'b1;
                        end else begin
                            Channel_L <= word_next;
                            shot_L    <= 1'b1;
                        end
                        // An exactly-W-bit slot: the LSB shares its cycle with
                        // the next edge, so restart immediately.
                        if (lrck_edge) begin
                            chan <= AUD_ADCLRCK;
                            cnt  <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (lrck_edge) begin
                        // Word cut short: drop it and start the new channel.
                        frame_error <= 1'b1;
                        chan        <= AUD_ADCLRCK;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Testbench for i2s_adc_receiver.
// The stimulus is built as per-cycle arrays of LRCK and DATA. A reference model
// walks the LRCK edges in those arrays and derives every expected publish or
// frame error, together with its cycle and the channel contents afterwards, and
// queues them. A separate monitor pops an entry whenever the DUT raises a strobe.
module tb_i2s_adc_receiver;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lrck = 1'b0;
    logic          dat = 1'b0;
    logic [W-1:0]  Channel_L, Channel_R;
    logic          shot_L, shot_R, frame_error;

    always #5 clk = ~clk;

    i2s_adc_receiver #(.WORD_LENGTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .Channel_L   (Channel_L),
        .Channel_R   (Channel_R),
        .shot_L      (shot_L),
        .shot_R      (shot_R),
        .frame_error (frame_error)
    );

    typedef enum int {EV_L = 0, EV_R = 1, EV_ERR = 2} ev_kind_e;
    typedef struct {
        ev_kind_e     kind;
        int           cyc;
        logic [W-1:0] ch_l;
        logic [W-1:0] ch_r;
    } ev_t;
    typedef struct {
        int           len;
        logic [W-1:0] word;
    } slot_t;

    ev_t          exp_q[$];
    slot_t        slots[$];
    bit           lrck_a[$];
    bit           dat_a[$];
    int           checks = 0;
    int           failures = 0;
    int           cur_cycle = 0;
    logic [W-1:0] mdl_l, mdl_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cur_cycle);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_channels"}, {Channel_L, Channel_R}, 32'h0);
        check({name, "_strobes"}, {29'h0, shot_L, shot_R, frame_error}, 32'h0);
    endtask

    // Build the per-cycle LRCK/DATA arrays. Slots alternate channel, starting
    // opposite to the hold level. Data not covered by a word is random, or all
    // ones when pad_ones is set.
    task automatic build(input bit hold_lvl, input int hold, input bit pad_ones);
        int starts[$];
        bit lvl;
        lrck_a.delete();
        dat_a.delete();
        lvl = hold_lvl;
        for (int i = 0; i < hold; i++) begin
            lrck_a.push_back(lvl);
            dat_a.push_back(bit'($urandom_range(0, 1)));
        end
        foreach (slots[s]) begin
            lvl = !lvl;
            starts.push_back(lrck_a.size());
            for (int i = 0; i < slots[s].len; i++) begin
                lrck_a.push_back(lvl);
                dat_a.push_back(pad_ones ? 1'b1 : bit'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < W + 4; i++) begin
            lrck_a.push_back(lvl);
            dat_a.push_back(pad_ones ? 1'b1 : bit'($urandom_range(0, 1)));
        end
        foreach (slots[s]) begin
            for (int k = 1; k <= W; k++) begin
                if (starts[s] + k < lrck_a.size())
                    dat_a[starts[s] + k] = slots[s].word[W - k];
            end
        end
    endtask

    // Reference model for the DUT running from an ARM cycle at 'from' up to
    // (not including) cycle 'to'. An edge opens a word whose bits follow it. The
    // word is published W cycles after the edge if the next edge is no sooner.
    // An earlier next edge raises a frame error in that cycle.
    task automatic model(input int from, input int to);
        int edges[$];
        int e, nxt;
        logic [W-1:0] w;
        for (int t = from + 1; t < to; t++)
            if (lrck_a[t] != lrck_a[t-1]) edges.push_back(t);
        foreach (edges[i]) begin
            e   = edges[i];
            nxt = (i + 1 < edges.size()) ? edges[i+1] : to;
            if (nxt - e >= W) begin
                if (e + W < to) begin
                    for (int k = 1; k <= W; k++) w[W - k] = dat_a[e + k];
                    if (lrck_a[e]) mdl_r = w; else mdl_l = w;
                    exp_q.push_back('{lrck_a[e] ? EV_R : EV_L, e + W, mdl_l, mdl_r});
                end
            end else if (i + 1 < edges.size()) begin
                exp_q.push_back('{EV_ERR, nxt, mdl_l, mdl_r});
            end
        end
    endtask

    // Assert reset asynchronously mid-cycle and check outputs clear and stay clear.
    task automatic start_test();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_zero("rst_async");
        repeat (3) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        mdl_l = '0;
        mdl_r = '0;
    endtask

    // Reset is released in the cycle before stream index 0, so cycle 0 is ARM.
    // When rst_at >= 0, reset is re-asserted mid-cycle before cycle rst_at and
    // released again 3 cycles later.
    task automatic drive(input int rst_at);
        for (int i = 0; i < lrck_a.size(); i++) begin
            @(negedge clk);
            cur_cycle = i;
            lrck = lrck_a[i];
            dat  = dat_a[i];
            if (i == 0) reset = 1'b0;
            if (rst_at >= 0 && i == rst_at + 3) reset = 1'b0;
            if (i == rst_at) begin
                #2 reset = 1'b1;
                #1 check_zero("rst_midword");
            end
        end
        repeat (3) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_simple(input bit hold_lvl, input int hold, input bit pad_ones);
        start_test();
        build(hold_lvl, hold, pad_ones);
        model(0, lrck_a.size());
        drive(-1);
    endtask

    // Monitor: consumes one expected event per DUT strobe.
    ev_t      mon_e;
    ev_kind_e mon_kind;
    always @(posedge clk) begin
        #1;
        if (!reset && (shot_L || shot_R || frame_error)) begin
            check("strobe_onehot", 32'(shot_L) + 32'(shot_R) + 32'(frame_error), 1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got L=%0b R=%0b err=%0b expected none (cycle %0d)",
                         shot_L, shot_R, frame_error, cur_cycle);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_kind = shot_L ? EV_L : (shot_R ? EV_R : EV_ERR);
                check("event_kind", mon_kind, mon_e.kind);
                check("event_cycle", cur_cycle, mon_e.cyc);
                check("channel_l", 32'(Channel_L), 32'(mon_e.ch_l));
                check("channel_r", 32'(Channel_R), 32'(mon_e.ch_r));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish (cycle %0d)", cur_cycle);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        mdl_l = '0;
        mdl_r = '0;
        repeat (2) @(negedge clk);

        // Constant LRCK after reset: nothing may be published.
        slots.delete();
        run_simple(1'b0, 40, 1'b0);

        // Single left word.
        slots.delete();
        slots.push_back('{20, 16'hA5C3});
        run_simple(1'b1, 6, 1'b0);

        // Back-to-back exact 16-bit slots, 4 frames.
        slots.delete();
        repeat (4) begin
            slots.push_back('{16, 16'h8001});
            slots.push_back('{16, 16'h7FFE});
        end
        run_simple(1'b1, 5, 1'b0);

        // 32-bit slots padded with ones.
        slots.delete();
        repeat (2) begin
            slots.push_back('{32, 16'h1234});
            slots.push_back('{32, 16'hFEDC});
        end
        run_simple(1'b1, 5, 1'b1);

        // Truncated left slot after a good frame, then a full right word.
        slots.delete();
        slots.push_back('{24, 16'h5A5A});
        slots.push_back('{20, 16'h3C3C});
        slots.push_back('{10, 16'hFFFF});
        slots.push_back('{20, 16'h0F0F});
        run_simple(1'b1, 5, 1'b0);

        // Reset at bit 8 of a left word, released 3 cycles later.
        slots.delete();
        slots.push_back('{32, 16'h1111});
        slots.push_back('{32, 16'h2222});
        slots.push_back('{32, 16'h3333});
        slots.push_back('{32, 16'h4444});
        slots.push_back('{32, 16'h5555});
        start_test();
        build(1'b1, 5, 1'b0);
        model(0, 77);
        mdl_l = '0;
        mdl_r = '0;
        model(80, lrck_a.size());
        drive(77);

        // Randomized slot lengths: truncated, exact and padded.
        for (int it = 0; it < 4; it++) begin
            slots.delete();
            for (int s = 0; s < 20; s++) begin
                r = $urandom_range(0, 9);
                if (r < 2)      slots.push_back('{$urandom_range(1, W - 1), W'($urandom)});
                else if (r < 5) slots.push_back('{W, W'($urandom)});
                else            slots.push_back('{$urandom_range(W + 1, 40), W'($urandom)});
            end
            run_simple(bit'($urandom_range(0, 1)), $urandom_range(2, 8), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
